// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage of the multi-cycle CPU.
// Holds PC and IR and fetches one instruction per instruction period over a
// request/acknowledge memory port. The next PC is committed on the sequencer's
// NextIns pulse, and PCWre=0 at that moment parks the unit in HALT.
// Optional feature: define IF_RETIRE_COUNT_EN to enable the retired-instruction
// counter on InsCount. Otherwise InsCount is tied to zero.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        NextIns,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] ExtImm,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic [31:0] IR,
  output logic [5:0]  OpCode,
  output logic        IRWre,
  output logic        InsValid,
  output logic        Halted,
  output logic [31:0] InsCount
);

  typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

  // The PC is word aligned, so the reset value is aligned as well.
  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  state_t             state;
  logic        [31:0] pcQ;
  logic        [31:0] pc4Q;
  logic        [31:0] irQ;
  logic        [31:0] pcTarget;
  logic signed [31:0] extImmS;

  assign extImmS = ExtImm;

  // Next-PC selection. The low two bits of every target are forced to zero.
  function automatic logic [31:0] nextPc(
    input logic        [31:0] pc,
    input logic        [31:0] pc4,
    input logic        [1:0]  src,
    input logic signed [31:0] ext,
    input logic        [31:0] ir
  );
    logic [31:0] t;
    case (src)
      2'b00:   t = pc4;
      2'b01:   t = pc4 + $unsigned(ext <<< 2);
      2'b10:   t = {pc4[31:28], ir[25:0], 2'b00};
      default: t = pc;
    endcase
    return {t[31:2], 2'b00};
  endfunction

  assign pcTarget  = nextPc(pcQ, pc4Q, PCSrc, extImmS, irQ);

  // The request is combinational from state. It is suppressed while reset is
  // held, and no IR write happens during reset either.
  assign imem_req  = (state == FETCH) && !Reset;
  assign imem_addr = pcQ;
  assign IRWre     = (state == FETCH) && imem_ack && !Reset;

  assign PC        = pcQ;
  assign PC4       = pc4Q;
  assign IR        = irQ;
  assign OpCode    = irQ[31:26];

  // Fetch sequencer: FETCH waits for ack, HOLD waits for NextIns, HALT is terminal.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= FETCH;
      pcQ      <= ResetPcAligned;
      pc4Q     <= ResetPcAligned + 32'd4;
      irQ      <= '0;
      InsValid <= 1'b0;
      Halted   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            irQ      <= imem_rdata;
            InsValid <= 1'b1;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (NextIns) begin
            if (PCWre) begin
              pcQ      <= pcTarget;
              pc4Q     <= pcTarget + 32'd4;
              InsValid <= 1'b0;
              state    <= FETCH;
            end else begin
              Halted   <= 1'b1;
              state    <= HALT;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

`ifdef IF_RETIRE_COUNT_EN
  logic [31:0] insCountQ;

  // Count every NextIns accepted in HOLD, including the one that halts.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      insCountQ <= '0;
    end else if ((state == HOLD) && NextIns) begin
      insCountQ <= insCountQ + 32'd1;
    end
  end

  assign InsCount = insCountQ;
`else
  assign InsCount = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a reference model.
module tb_if_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        NextIns = 1'b0;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ExtImm = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;

  logic        imem_req, IRWre, InsValid, Halted;
  logic [31:0] imem_addr, PC, PC4, IR, InsCount;
  logic [5:0]  OpCode;

  logic        reqB, irwreB, validB, haltedB;
  logic [31:0] addrB, pcB, pc4B, irB, cntB;
  logic [5:0]  opB;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset(Reset), .NextIns(NextIns), .PCWre(PCWre), .PCSrc(PCSrc),
    .ExtImm(ExtImm), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(PC), .PC4(PC4), .IR(IR),
    .OpCode(OpCode), .IRWre(IRWre), .InsValid(InsValid), .Halted(Halted),
    .InsCount(InsCount)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .CLK(CLK), .Reset(Reset), .NextIns(NextIns), .PCWre(PCWre), .PCSrc(PCSrc),
    .ExtImm(ExtImm), .imem_req(reqB), .imem_addr(addrB),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PC(pcB), .PC4(pc4B), .IR(irB),
    .OpCode(opB), .IRWre(irwreB), .InsValid(validB), .Halted(haltedB),
    .InsCount(cntB)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nPass = 0;

  typedef struct {
    logic        rst, nxt, wre;
    logic [1:0]  src;
    logic [31:0] ext;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic        irwre;
    logic [31:0] pc, ir;
    logic        valid, halted;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  function automatic logic [31:0] expCnt(input logic [31:0] c);
`ifdef IF_RETIRE_COUNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction

  task automatic drive(input logic rst, input logic nxt, input logic wre, input logic [1:0] src,
                       input logic [31:0] ext, input logic ack, input logic [31:0] rdata);
    Reset = rst; NextIns = nxt; PCWre = wre; PCSrc = src;
    ExtImm = ext; imem_ack = ack; imem_rdata = rdata;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic addRow(input logic rst, input logic nxt, input logic wre, input logic [1:0] src,
                        input logic [31:0] ext, input logic ack, input logic [31:0] rdata,
                        input logic req, input logic [31:0] addr, input logic irwre,
                        input logic [31:0] pc, input logic [31:0] ir, input logic valid,
                        input logic halted, input logic [31:0] cnt);
    vec_t v;
    v.rst = rst; v.nxt = nxt; v.wre = wre; v.src = src; v.ext = ext; v.ack = ack;
    v.rdata = rdata; v.req = req; v.addr = addr; v.irwre = irwre; v.pc = pc; v.ir = ir;
    v.valid = valid; v.halted = halted; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Instruction memory contents used by the random phase.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Next PC computed from the architectural rules with plain arithmetic.
  function automatic logic [31:0] refTarget(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic [31:0] ext, input logic [1:0] src);
    logic [31:0] seq;
    logic [31:0] r;
    seq = pc + 32'd4;
    case (src)
      2'd0:    r = seq;
      2'd1:    r = seq + ext * 32'd4;
      2'd2:    r = (seq & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
      default: r = pc;
    endcase
    return r & 32'hFFFF_FFFC;
  endfunction

  initial begin
    logic [31:0] mPc, mIr, mCnt;
    logic        mValid, mHalted, mFetching;
    logic        rRst, rNxt, rWre, rAck;
    logic [1:0]  rSrc;
    logic [31:0] rExt, rData;

    // rst nxt wre src ext ack rdata | req addr irwre | pc ir valid halted cnt
    addRow(1'b1,1'b0,1'b0,2'd0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b0,  32'h0,32'h0,1'b0,1'b0,32'd0);
    addRow(1'b1,1'b0,1'b0,2'd0,32'h0,1'b1,32'hDEAD_BEEF,  1'b0,32'h0,1'b0,  32'h0,32'h0,1'b0,1'b0,32'd0);
    addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h0000_0001,  1'b1,32'h0,1'b1,  32'h0,32'h1,1'b1,1'b0,32'd0);
    addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'hDEAD_BEEF,  1'b0,32'h0,1'b0,  32'h0,32'h1,1'b1,1'b0,32'd0);
    addRow(1'b0,1'b1,1'b1,2'd0,32'h0,1'b0,32'h0,          1'b0,32'h0,1'b0,  32'h4,32'h1,1'b0,1'b0,32'd1);
    for (int i = 0; i < 3; i++)
      addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b0,32'hBAD0_0000,1'b1,32'h4,1'b0,  32'h4,32'h1,1'b0,1'b0,32'd1);
    addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h2000_0002,  1'b1,32'h4,1'b1,  32'h4,32'h2000_0002,1'b1,1'b0,32'd1);
    addRow(1'b0,1'b1,1'b1,2'd0,32'h0,1'b0,32'h0,          1'b0,32'h4,1'b0,  32'h8,32'h2000_0002,1'b0,1'b0,32'd2);
    for (int i = 0; i < 3; i++)
      addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b0,32'hBAD0_0000,1'b1,32'h8,1'b0,  32'h8,32'h2000_0002,1'b0,1'b0,32'd2);
    addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h3000_0003,  1'b1,32'h8,1'b1,  32'h8,32'h3000_0003,1'b1,1'b0,32'd2);
    addRow(1'b0,1'b1,1'b1,2'd1,32'hFFFF_FFFE,1'b0,32'h0,  1'b0,32'h8,1'b0,  32'h4,32'h3000_0003,1'b0,1'b0,32'd3);
    addRow(1'b0,1'b1,1'b1,2'd2,32'h0,1'b0,32'h0,          1'b1,32'h4,1'b0,  32'h4,32'h3000_0003,1'b0,1'b0,32'd3);
    addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h0800_0010,  1'b1,32'h4,1'b1,  32'h4,32'h0800_0010,1'b1,1'b0,32'd3);
    addRow(1'b0,1'b1,1'b1,2'd2,32'h0,1'b0,32'h0,          1'b0,32'h4,1'b0,  32'h40,32'h0800_0010,1'b0,1'b0,32'd4);
    addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h0C00_0000,  1'b1,32'h40,1'b1, 32'h40,32'h0C00_0000,1'b1,1'b0,32'd4);
    addRow(1'b0,1'b1,1'b1,2'd3,32'h0,1'b0,32'h0,          1'b0,32'h40,1'b0, 32'h40,32'h0C00_0000,1'b0,1'b0,32'd5);
    addRow(1'b0,1'b0,1'b0,2'd0,32'h0,1'b1,32'h0C00_0001,  1'b1,32'h40,1'b1, 32'h40,32'h0C00_0001,1'b1,1'b0,32'd5);
    addRow(1'b0,1'b1,1'b0,2'd0,32'h0,1'b0,32'h0,          1'b0,32'h40,1'b0, 32'h40,32'h0C00_0001,1'b1,1'b1,32'd6);
    addRow(1'b0,1'b1,1'b1,2'd0,32'h0,1'b1,32'hFFFF_FFFF,  1'b0,32'h40,1'b0, 32'h40,32'h0C00_0001,1'b1,1'b1,32'd6);

    // Directed vector table
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].nxt, tbl[i].wre, tbl[i].src, tbl[i].ext, tbl[i].ack, tbl[i].rdata);
      #2;
      check($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
      if (!tbl[i].rst) begin
        check($sformatf("vec%0d_addr", i), imem_addr, tbl[i].addr);
        check($sformatf("vec%0d_irwre", i), {31'd0, IRWre}, {31'd0, tbl[i].irwre});
      end
      tick();
      check($sformatf("vec%0d_pc", i), PC, tbl[i].pc);
      check($sformatf("vec%0d_pc4", i), PC4, tbl[i].pc + 32'd4);
      check($sformatf("vec%0d_ir", i), IR, tbl[i].ir);
      check($sformatf("vec%0d_opcode", i), {26'd0, OpCode}, {26'd0, tbl[i].ir[31:26]});
      check($sformatf("vec%0d_valid", i), {31'd0, InsValid}, {31'd0, tbl[i].valid});
      check($sformatf("vec%0d_halted", i), {31'd0, Halted}, {31'd0, tbl[i].halted});
      check($sformatf("vec%0d_cnt", i), InsCount, expCnt(tbl[i].cnt));
    end

    // Halted for 20 cycles: no requests, NextIns and ack ignored
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom % 2), 1'b1, 2'($urandom % 4), $urandom, 1'($urandom % 2), $urandom);
      #2;
      check("halt_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("halt_flag", {31'd0, Halted}, 32'd1);
      check("halt_pc", PC, 32'h40);
      check("halt_valid", {31'd0, InsValid}, 32'd1);
      check("halt_cnt", InsCount, expCnt(32'd6));
    end

    // Reset leaves HALT, then reset again in the middle of a fetch
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    tick();
    check("rst_halted", {31'd0, Halted}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    #2;
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h1234_5678);
    #2;
    check("midfetch_req_drop", {31'd0, imem_req}, 32'd0);
    tick();
    check("midfetch_ir", IR, 32'h0);
    check("midfetch_valid", {31'd0, InsValid}, 32'd0);
    check("midfetch_pc", PC, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    #2;
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    tick();

    // Wrap-around on the instance reset to 32'hFFFF_FFFC
    drive(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0);
    tick();
    check("wrap_rst_pc", pcB, 32'hFFFF_FFFC);
    check("wrap_rst_pc4", pc4B, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0000_0000);
    #2;
    check("wrap_addr0", addrB, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'd3, 32'h0, 1'b0, 32'h0);
    tick();
    check("wrap_hold_pc", pcB, 32'hFFFF_FFFC);
    check("wrap_hold_valid", {31'd0, validB}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0);
    #2;
    check("wrap_refetch_req", {31'd0, reqB}, 32'd1);
    check("wrap_refetch_addr", addrB, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 1'b1, 1'b1, 2'd0, 32'h0, 1'b0, 32'h0);
    tick();
    check("wrap_pc", pcB, 32'h0);
    check("wrap_pc4", pc4B, 32'h4);

    // Randomized traffic against the reference model
    mPc = '0; mIr = '0; mCnt = '0; mValid = 1'b0; mHalted = 1'b0; mFetching = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rRst  = (cyc == 0) || ($urandom % 64 == 0);
      rNxt  = ($urandom % 3 == 0);
      rWre  = ($urandom % 16 != 0);
      rSrc  = 2'($urandom % 4);
      rExt  = $urandom;
      rAck  = ($urandom % 2 == 0);
      rData = rAck ? memWord(mPc) : $urandom;
      drive(rRst, rNxt, rWre, rSrc, rExt, rAck, rData);
      #2;
      check("rand_req", {31'd0, imem_req}, {31'd0, mFetching && !rRst});
      if (!rRst) begin
        if (mFetching) check("rand_addr", imem_addr, mPc);
        check("rand_irwre", {31'd0, IRWre}, {31'd0, mFetching && rAck});
      end
      tick();
      if (rRst) begin
        mPc = '0; mIr = '0; mCnt = '0; mValid = 1'b0; mHalted = 1'b0; mFetching = 1'b1;
      end else if (mFetching) begin
        if (rAck) begin
          mIr = rData; mValid = 1'b1; mFetching = 1'b0;
        end
      end else if (!mHalted && rNxt) begin
        mCnt = mCnt + 32'd1;
        if (rWre) begin
          mPc = refTarget(mPc, mIr, rExt, rSrc);
          mValid = 1'b0;
          mFetching = 1'b1;
        end else begin
          mHalted = 1'b1;
        end
      end
      check("rand_pc", PC, mPc);
      check("rand_pc4", PC4, mPc + 32'd4);
      check("rand_ir", IR, mIr);
      check("rand_valid", {31'd0, InsValid}, {31'd0, mValid});
      check("rand_halted", {31'd0, Halted}, {31'd0, mHalted});
      check("rand_cnt", InsCount, expCnt(mCnt));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the multi-cycle CPU, directly upstream of the control unit. Holds the program counter and instruction register, and fetches one instruction per instruction period over a request/acknowledge instruction-memory port. Presents `OpCode` to the control unit. Computes the next PC from the control unit's `PCSrc`/`PCWre` when the sequencer signals end of instruction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

- `CLK`  in  1  clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `NextIns`  in  1  one-cycle pulse from the sequencer: commit next PC and start the next fetch.
- `PCWre`  in  1  from control unit; 0 = halt instruction, PC frozen.
- `PCSrc`  in  2  from control unit; 00 PC+4, 01 branch, 10 jump, 11 hold PC.
- `ExtImm`  in  32  sign-extended immediate from the extender (branch offset, in words).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address.
- `imem_ack`  in  1  read data valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `PC`  out  32  current PC.
- `PC4`  out  32  PC+4.
- `IR`  out  32  instruction register.
- `OpCode`  out  6  `IR[31:26]`.
- `IRWre`  out  1  IR load strobe.
- `InsValid`  out  1  IR holds the instruction at `PC`.
- `Halted`  out  1  halt state reached.
- `InsCount`  out  32  retired-instruction count (see Configuration).

## Operation
- States: FETCH, HOLD, HALT.
- FETCH:
  - `imem_req`=1 and `imem_addr`=`PC`.
  - On `imem_ack`: `IR`<=`imem_rdata`, `InsValid`<=1, go to HOLD.
- HOLD:
  - `IR` and `PC` are stable.
  - On `NextIns` with `PCWre`=1: `PC`<=next PC, `InsValid`<=0, go to FETCH.
  - On `NextIns` with `PCWre`=0: go to HALT.
- HALT:
  - Terminal; only `Reset` leaves it.
  - `PC`, `IR` and `InsValid`=1 are held; `Halted`=1.
- Next PC, sampled on the `NextIns` cycle:
  - 00: `PC4`.
  - 01: `PC4 + (ExtImm<<2)`.
  - 10: `{PC4[31:28], IR[25:0], 2'b00}`.
  - 11: `PC`.
- Arithmetic is 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
- `PC[1:0]` is always 00; the low bits of any computed target are forced to 00.
- `IRWre` = (state==FETCH) && `imem_ack`, combinational.
- Ignored events:
  - `imem_ack` outside FETCH.
  - `NextIns` in FETCH or HALT.
  - `PCSrc` and `PCWre` outside the `NextIns` cycle.
- Reset values:
  - `PC`=`RESET_PC`, `IR`=0, state=FETCH.
  - `InsValid`=0, `Halted`=0, `InsCount`=0.
  - `imem_req`=0 while `Reset` is high.

## Timing
- `imem_req`, `imem_addr` and `IRWre` are combinational from state and `PC`; all other outputs are registered.
- Zero-wait memory:
  - `imem_ack` may be high in the first FETCH cycle.
  - `IR` is valid the next cycle, so minimum fetch latency is 1 cycle.
- `imem_addr` stays stable while `imem_req`=1 until acknowledged; there are no back-to-back requests without an intervening HOLD.
- `NextIns` in HOLD: the new `PC` is visible next cycle, and FETCH (`imem_req`=1) starts that same cycle.
- Reset mid-fetch:
  - `imem_req` drops in the reset cycle.
  - A late `imem_ack` arriving during `Reset` is discarded.
  - A fresh fetch from `RESET_PC` starts the cycle after `Reset` falls.
- `Reset` has priority over all other inputs.

## Configuration
- `IF_RETIRE_COUNT_EN` defined:
  - `InsCount` increments by 1 on every `NextIns` accepted in HOLD, including the one that causes HALT.
  - Wraps at 2^32; reset to 0.
- Not defined: `InsCount` is tied to 0 and the counter logic is absent.

## Test plan
- Reset, then zero-wait ack with rdata 32'h0000_0001:
  - `imem_addr`=0 in cycle 1.
  - `IR`=32'h0000_0001 and `InsValid`=1 in cycle 2.
  - `IRWre` high only in cycle 1.
- Sequential flow, `PCSrc`=00, 3 wait cycles on ack per fetch: addresses 0, 4, 8.
  - `imem_addr` is held stable during waits.
  - `InsCount`=3 after three `NextIns` (macro on).
- Branch at PC=8 with `ExtImm`=-2 and `PCSrc`=01: next `PC`=4.
- Jump with `IR[25:0]`=26'h10 and `PCSrc`=10: next `PC`=32'h40.
- Wrap-around:
  - Starting from `RESET_PC`=32'hFFFF_FFFC, `PCSrc`=00 gives next `PC`=0.
  - `PCSrc`=11 keeps `PC` unchanged and refetches.
- `PCWre`=0 at `NextIns`:
  - `Halted`=1 and `imem_req` stays 0 for 20 cycles; further `NextIns` pulses are ignored.
  - `Reset` mid-fetch then restarts at `RESET_PC` with `Halted`=0.
